// File: rtl/card_dealer_pkg.sv
// ---------------------------------------------------------------------------
// card_dealer_pkg
//
// Purpose:
//   Shared definitions for the card dealer and the blackjack game FSM that
//   consumes its cards. Holds the dealer state encoding, the LFSR constants,
//   the card word width and the rank-to-blackjack-value mapping.
//
// Contents:
//   CARD_W, IDX_W      card value width and deck index width
//   LFSR_TAPS          Galois feedback taps of the shuffle LFSR
//   DEFAULT_SEED       seed used whenever a seed of zero is requested
//   card_t             card value type shared with the game FSM
//   dealer_state_e     FILL / SHUFFLE / READY / DEAL
//   rank_value()       rank 0..12 -> blackjack value 1..10
// ---------------------------------------------------------------------------
package card_dealer_pkg;

    localparam int CARD_W = 4;
    localparam int IDX_W  = 6;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Highest rank index in a suit (ace=0 .. king=12).
    localparam logic [3:0] LAST_RANK = 4'd12;

    // The game FSM declares its card inputs with this type so both sides
    // agree on the width of a dealt value.
    typedef logic [CARD_W-1:0] card_t;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_SHUFFLE = 2'd1,
        ST_READY   = 2'd2,
        ST_DEAL    = 2'd3
    } dealer_state_e;

    // Ace counts as 1, two..ten count face value, jack/queen/king count 10.
    function automatic card_t rank_value(input logic [3:0] rank);
        card_t value;
        if (rank == 4'd0) begin
            value = card_t'(1);
        end else if (rank <= 4'd9) begin
            value = rank + 4'd1;
        end else begin
            value = card_t'(10);
        end
        return value;
    endfunction

endpackage

// File: rtl/card_dealer_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
//
// Purpose:
//   16-bit Galois LFSR, right-shifting. When the bit shifted out is 1 the
//   register is XORed with TAPS. Intended as a general random source, not
//   only for the card dealer.
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous, active-low reset (loads RESET_VALUE)
//   en_i          advance one step this cycle
//   load_i        load load_value_i this cycle (wins over en_i)
//   load_value_i  value loaded when load_i is high
//   state_o       current LFSR contents
// ---------------------------------------------------------------------------
module lfsr16
    import card_dealer_pkg::*;
#(
    parameter logic [15:0] RESET_VALUE = DEFAULT_SEED,
    parameter logic [15:0] TAPS        = LFSR_TAPS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [15:0] load_value_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // A load overrides stepping so a reseed takes effect on a known cycle.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = load_value_i;
        end else if (en_i) begin
            state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RESET_VALUE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/card_dealer.sv
// ---------------------------------------------------------------------------
// card_dealer
//
// Purpose:
//   Card source for the blackjack game FSM. Holds one deck of DECK_SIZE
//   cards, fills it in rank order, shuffles it in place with an LFSR-driven
//   Fisher-Yates pass (rejection sampling for out-of-range candidates), then
//   deals one blackjack value per request. The deck is rebuilt after reset,
//   on a shuffle pulse and automatically once the last card has been dealt.
//
// Parameters:
//   SEED       LFSR seed loaded at reset (0 is replaced by DEFAULT_SEED)
//   DECK_SIZE  cards per deck, a multiple of 13 and at most 63
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous, active-low reset
//   card_req    level request, held by the requester until card_valid
//   shuffle     one-cycle pulse: refill and reshuffle the deck
//   card_value  last dealt value (1=ace, 2..10), 0 after reset
//   card_valid  one-cycle pulse marking a freshly dealt card_value
//   ready       deck shuffled and a request can be accepted
//   cards_left  undealt cards remaining
//   busy        fill or shuffle in progress
//
// Optional build macro CARD_DEALER_SEED_EN:
//   Adds inputs seed[15:0] and seed_load. A seed_load pulse loads the LFSR
//   with seed (0 replaced by the effective SEED) and restarts the deck like
//   shuffle, so a deal order can be reproduced. Without the macro the LFSR
//   is only seeded at reset.
// ---------------------------------------------------------------------------
module card_dealer
    import card_dealer_pkg::*;
#(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          DECK_SIZE = 52
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              card_req,
    input  logic              shuffle,
`ifdef CARD_DEALER_SEED_EN
    input  logic [15:0]       seed,
    input  logic              seed_load,
`endif
    output logic [CARD_W-1:0] card_value,
    output logic              card_valid,
    output logic              ready,
    output logic [IDX_W-1:0]  cards_left,
    output logic              busy
);

    localparam logic [15:0]      SEED_EFF   = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DECK_SIZE - 1);
    localparam logic [IDX_W-1:0] FULL_COUNT = IDX_W'(DECK_SIZE);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

    dealer_state_e    state_q;
    dealer_state_e    state_d;

    card_t            deck_q [DECK_SIZE];

    // Write index during FILL, Fisher-Yates index i during SHUFFLE.
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [3:0]       rank_q;
    logic [3:0]       rank_d;
    logic [IDX_W-1:0] left_q;
    logic [IDX_W-1:0] left_d;
    card_t            value_q;
    card_t            value_d;
    logic             valid_q;
    logic             valid_d;

    logic             fill_we;
    logic             swap_en;
    logic             restart;

    logic [15:0]      lfsr_state;
    logic             lfsr_load;
    logic [15:0]      lfsr_load_value;
    logic [IDX_W-1:0] cand_j;
    logic             unused_lfsr_bits;

    // -----------------------------------------------------------------------
    // Random source. It steps every cycle regardless of state, so each
    // reshuffle starts from a different point and successive decks differ.
    // -----------------------------------------------------------------------
`ifdef CARD_DEALER_SEED_EN
    assign lfsr_load       = seed_load;
    assign lfsr_load_value = (seed == 16'h0000) ? SEED_EFF : seed;
    assign restart         = shuffle | seed_load;
`else
    assign lfsr_load       = 1'b0;
    assign lfsr_load_value = SEED_EFF;
    assign restart         = shuffle;
`endif

    lfsr16 #(
        .RESET_VALUE (SEED_EFF),
        .TAPS        (LFSR_TAPS)
    ) u_lfsr (
        .clock        (clock),
        .reset        (reset),
        .en_i         (1'b1),
        .load_i       (lfsr_load),
        .load_value_i (lfsr_load_value),
        .state_o      (lfsr_state)
    );

    // Only the low bits form the swap candidate; 6 bits covers any legal deck.
    assign cand_j           = lfsr_state[IDX_W-1:0];
    assign unused_lfsr_bits = ^lfsr_state[15:IDX_W];

    // -----------------------------------------------------------------------
    // Next-state and datapath control. A restart request (shuffle or seed
    // load) overrides everything, including a request accepted in the same
    // cycle, which is therefore dropped without a card_valid.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rank_d  = rank_q;
        left_d  = left_q;
        value_d = value_q;
        valid_d = 1'b0;
        fill_we = 1'b0;
        swap_en = 1'b0;

        if (restart) begin
            state_d = ST_FILL;
            idx_d   = '0;
            rank_d  = '0;
            left_d  = '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    fill_we = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = LAST_IDX;
                        rank_d  = '0;
                        state_d = ST_SHUFFLE;
                    end else begin
                        idx_d  = idx_q + IDX_ONE;
                        rank_d = (rank_q == LAST_RANK) ? 4'd0 : rank_q + 4'd1;
                    end
                end

                // Candidates above i are rejected rather than reduced modulo
                // i+1, which keeps every permutation equally likely.
                ST_SHUFFLE: begin
                    if (cand_j <= idx_q) begin
                        swap_en = 1'b1;
                        idx_d   = idx_q - IDX_ONE;
                        if (idx_q == IDX_ONE) begin
                            left_d  = FULL_COUNT;
                            state_d = ST_READY;
                        end
                    end
                end

                // Cards are dealt from the top of the shuffled array down.
                ST_READY: begin
                    if (card_req) begin
                        value_d = deck_q[left_q - IDX_ONE];
                        valid_d = 1'b1;
                        left_d  = left_q - IDX_ONE;
                        state_d = ST_DEAL;
                    end
                end

                // One cycle with ready low, so a held request yields one card.
                ST_DEAL: begin
                    if (left_q == '0) begin
                        idx_d   = '0;
                        rank_d  = '0;
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_READY;
                    end
                end

                default: begin
                    idx_d   = '0;
                    rank_d  = '0;
                    left_d  = '0;
                    state_d = ST_FILL;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Control registers. Reset lands directly in FILL, so the first clock
    // after release writes the first deck entry.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FILL;
            idx_q   <= '0;
            rank_q  <= '0;
            left_q  <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rank_q  <= rank_d;
            left_q  <= left_d;
            value_q <= value_d;
            valid_q <= valid_d;
        end
    end

    // -----------------------------------------------------------------------
    // Deck storage. When j equals i both writes carry the same value, so
    // the degenerate swap is harmless.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DECK_SIZE; k++) begin
                deck_q[k] <= '0;
            end
        end else if (fill_we) begin
            deck_q[idx_q] <= rank_value(rank_q);
        end else if (swap_en) begin
            deck_q[idx_q]  <= deck_q[cand_j];
            deck_q[cand_j] <= deck_q[idx_q];
        end
    end

    assign card_value = value_q;
    assign card_valid = valid_q;
    assign cards_left = left_q;
    assign ready      = (state_q == ST_READY);
    assign busy       = (state_q == ST_FILL) || (state_q == ST_SHUFFLE);

endmodule
